// File: rtl/cv32e40p_tmr_fault_manager_if.sv
// cv32e40p_tmr_fault_manager_if: voter flag inputs and fault-state outputs of the TMR fault manager
interface cv32e40p_tmr_fault_manager_if #(
    parameter int CNT_WIDTH = 4
);
    logic                     valid_i;
    logic                     err_detected_1_i;
    logic                     err_detected_2_i;
    logic                     err_detected_3_i;
    logic                     err_corrected_i;
    logic [2:0]               force_broken_i;
    logic                     clear_i;
    logic [2:0]               broken_block_o;
    logic [1:0]               state_o;
    logic                     fatal_o;
    logic                     fault_event_o;
    logic [3*CNT_WIDTH-1:0]   err_cnt_o;

    modport master (
        output valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i,
               err_corrected_i, force_broken_i, clear_i,
        input  broken_block_o, state_o, fatal_o, fault_event_o, err_cnt_o
    );

    modport slave (
        input  valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i,
               err_corrected_i, force_broken_i, clear_i,
        output broken_block_o, state_o, fatal_o, fault_event_o, err_cnt_o
    );
endinterface

// File: rtl/cv32e40p_tmr_fault_manager.sv
// cv32e40p_tmr_fault_manager: per-replica leaky error counters, sticky broken mask and redundancy-level FSM
module cv32e40p_tmr_fault_manager #(
    parameter int ERR_THRESHOLD = 4,
    parameter int CNT_WIDTH     = 4,
    parameter int DECAY_PERIOD  = 256
) (
    input logic                           clk,
    input logic                           rst_n,
    cv32e40p_tmr_fault_manager_if.slave   bus
);
    localparam int TW = DECAY_PERIOD > 1 ? $clog2(DECAY_PERIOD) : 1;

    typedef enum logic [1:0] {TMR, DMR, SIMPLEX, FATAL} state_t;

    state_t                state, state_n;
    logic [2:0]            broken, broken_n, flags, hit;
    logic [CNT_WIDTH-1:0]  cnt [3];
    logic [CNT_WIDTH-1:0]  cnt_n [3];
    logic [TW-1:0]         tmr [3];
    logic [TW-1:0]         tmr_n [3];
    logic                  fault_event, active, single, fatal_n;
    int                    pc;

    // attribution, decay, broken-mask union and next redundancy level
    always_comb begin
        flags  = {bus.err_detected_3_i, bus.err_detected_2_i, bus.err_detected_1_i};
        active = state == TMR && bus.valid_i;
        single = $onehot(flags) && bus.err_corrected_i;
        for (int k = 0; k < 3; k++) begin
            cnt_n[k] = cnt[k];
            tmr_n[k] = tmr[k];
            hit[k]   = 1'b0;
            if (active && !broken[k]) begin
                if (flags[k]) begin
                    tmr_n[k] = '0;
                    if (single) begin
                        cnt_n[k] = &cnt[k] ? cnt[k] : cnt[k] + 1'b1;
                        hit[k]   = 32'(cnt[k]) + 1 >= ERR_THRESHOLD;
                    end
                end else if (DECAY_PERIOD != 0) begin
                    if (32'(tmr[k]) == DECAY_PERIOD - 1) begin
                        tmr_n[k] = '0;
                        cnt_n[k] = cnt[k] == '0 ? cnt[k] : cnt[k] - 1'b1;
                    end else begin
                        tmr_n[k] = tmr[k] + 1'b1;
                    end
                end
            end
        end
        broken_n = state == FATAL ? broken : broken | hit | bus.force_broken_i;
        pc       = $countones(broken_n);
        fatal_n  = state == FATAL || pc == 3
                || (state == TMR && bus.valid_i && &flags && !bus.err_corrected_i)
                || (state == DMR && bus.valid_i && (flags & ~broken) == ~broken);
        state_n  = fatal_n ? FATAL : pc == 2 ? SIMPLEX : pc == 1 ? DMR : TMR;
    end

    // fault state registers; clear_i overrides every other input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.clear_i) begin
            state       <= TMR;
            broken      <= '0;
            fault_event <= 1'b0;
            cnt         <= '{default: '0};
            tmr         <= '{default: '0};
        end else begin
            state       <= state_n;
            broken      <= broken_n;
            fault_event <= |(broken_n & ~broken);
            cnt         <= cnt_n;
            tmr         <= tmr_n;
        end
    end

    assign bus.broken_block_o = broken;
    assign bus.state_o        = state;
    assign bus.fatal_o        = state == FATAL;
    assign bus.fault_event_o  = fault_event;
    assign bus.err_cnt_o      = {cnt[2], cnt[1], cnt[0]};
endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// tb_cv32e40p_tmr_fault_manager: directed checks of thresholding, decay, FSM transitions, clear and reset
module tb_cv32e40p_tmr_fault_manager;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    cv32e40p_tmr_fault_manager_if #(.CNT_WIDTH(4)) bus ();

    cv32e40p_tmr_fault_manager #(
        .ERR_THRESHOLD(4),
        .CNT_WIDTH(4),
        .DECAY_PERIOD(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [2:0] bb, input logic [1:0] st,
                              input logic fe, input logic [11:0] cnt);
        chk({tag, ".broken"}, 32'(bus.broken_block_o), 32'(bb));
        chk({tag, ".state"}, 32'(bus.state_o), 32'(st));
        chk({tag, ".fatal"}, 32'(bus.fatal_o), 32'(st == 2'b11));
        chk({tag, ".event"}, 32'(bus.fault_event_o), 32'(fe));
        chk({tag, ".cnt"}, 32'(bus.err_cnt_o), 32'(cnt));
    endtask

    task automatic step(input logic v, input logic [2:0] f, input logic c,
                        input logic [2:0] fb, input logic clr);
        bus.valid_i          = v;
        bus.err_detected_1_i = f[0];
        bus.err_detected_2_i = f[1];
        bus.err_detected_3_i = f[2];
        bus.err_corrected_i  = c;
        bus.force_broken_i   = fb;
        bus.clear_i          = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 3'b000, 0, 3'b000, 0);
        expect_all("reset", 3'b000, 2'b00, 0, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        // threshold on replica 2
        repeat (3) step(1, 3'b010, 1, 3'b000, 0);
        expect_all("thr3", 3'b000, 2'b00, 0, 12'h030);
        step(1, 3'b010, 1, 3'b000, 0);
        expect_all("thr4", 3'b010, 2'b01, 1, 12'h040);
        step(1, 3'b010, 1, 3'b000, 0);
        expect_all("thr_sat", 3'b010, 2'b01, 0, 12'h040);
        step(0, 3'b000, 0, 3'b000, 1);
        expect_all("clr1", 3'b000, 2'b00, 0, 12'h000);
        // decay on replica 1
        repeat (3) step(1, 3'b001, 1, 3'b000, 0);
        expect_all("dec_load", 3'b000, 2'b00, 0, 12'h003);
        repeat (15) step(1, 3'b000, 0, 3'b000, 0);
        expect_all("dec_15", 3'b000, 2'b00, 0, 12'h003);
        step(1, 3'b000, 0, 3'b000, 0);
        expect_all("dec_16", 3'b000, 2'b00, 0, 12'h002);
        repeat (16) step(1, 3'b000, 0, 3'b000, 0);
        expect_all("dec_32", 3'b000, 2'b00, 0, 12'h001);
        repeat (16) step(0, 3'b000, 0, 3'b000, 0);
        expect_all("dec_invalid", 3'b000, 2'b00, 0, 12'h001);
        // uncorrectable error in TMR
        step(1, 3'b111, 0, 3'b000, 0);
        expect_all("unc", 3'b000, 2'b11, 0, 12'h001);
        step(0, 3'b000, 0, 3'b001, 0);
        expect_all("unc_sticky", 3'b000, 2'b11, 0, 12'h001);
        step(0, 3'b000, 0, 3'b000, 1);
        expect_all("clr2", 3'b000, 2'b00, 0, 12'h000);
        // DMR handling
        step(0, 3'b000, 0, 3'b001, 0);
        expect_all("dmr_force", 3'b001, 2'b01, 1, 12'h000);
        step(1, 3'b001, 1, 3'b000, 0);
        expect_all("dmr_ign", 3'b001, 2'b01, 0, 12'h000);
        step(1, 3'b110, 1, 3'b000, 0);
        expect_all("dmr_fatal", 3'b001, 2'b11, 0, 12'h000);
        step(0, 3'b000, 0, 3'b000, 1);
        expect_all("clr3", 3'b000, 2'b00, 0, 12'h000);
        // forcing through DMR, SIMPLEX, FATAL
        step(0, 3'b000, 0, 3'b100, 0);
        expect_all("f100", 3'b100, 2'b01, 1, 12'h000);
        step(0, 3'b000, 0, 3'b010, 0);
        expect_all("f010", 3'b110, 2'b10, 1, 12'h000);
        step(0, 3'b000, 0, 3'b010, 0);
        expect_all("f_again", 3'b110, 2'b10, 0, 12'h000);
        step(1, 3'b001, 1, 3'b000, 0);
        expect_all("simplex_ign", 3'b110, 2'b10, 0, 12'h000);
        step(0, 3'b000, 0, 3'b001, 0);
        expect_all("f001", 3'b111, 2'b11, 1, 12'h000);
        step(1, 3'b010, 1, 3'b000, 1);
        expect_all("clr_flag", 3'b000, 2'b00, 0, 12'h000);
        step(1, 3'b010, 1, 3'b001, 1);
        expect_all("clr_force", 3'b000, 2'b00, 0, 12'h000);
        // async reset mid-operation
        repeat (3) step(1, 3'b001, 1, 3'b000, 0);
        step(0, 3'b000, 0, 3'b100, 0);
        expect_all("pre_rst", 3'b100, 2'b01, 1, 12'h003);
        step(0, 3'b000, 0, 3'b000, 0);
        #3 rst_n = 1'b0;
        #1;
        expect_all("async_rst", 3'b000, 2'b00, 0, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1, 3'b001, 1, 3'b000, 0);
        expect_all("post_rst3", 3'b000, 2'b00, 0, 12'h003);
        step(1, 3'b001, 1, 3'b000, 0);
        expect_all("post_rst4", 3'b001, 2'b01, 1, 12'h004);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
